// File: rtl/eth_100g_tx_sf_buffer.sv
// eth_100g_tx_sf_buffer: store-and-forward TX frame buffer for the 100G MAC 512-bit Avalon-ST port.
// Optional statistics counters are built when ETH_TX_SF_STATS_EN is defined.
module eth_100g_tx_sf_buffer #(
    parameter int DEPTH           = 128,
    parameter int PKT_DEPTH       = 16,
    parameter int MAX_FRAME_WORDS = 64
) (
    input  logic                           i_clk_tx,
    input  logic                           i_tx_rst_n,
    input  logic                           i_us_valid,
    output logic                           o_us_ready,
    input  logic [511:0]                   i_us_data,
    input  logic                           i_us_sop,
    input  logic                           i_us_eop,
    input  logic [5:0]                     i_us_empty,
    input  logic                           i_us_error,
    output logic                           o_tx_valid,
    input  logic                           i_tx_ready,
    output logic [511:0]                   o_tx_data,
    output logic                           o_tx_startofpacket,
    output logic                           o_tx_endofpacket,
    output logic [5:0]                     o_tx_empty,
    output logic                           o_tx_error,
    output logic [$clog2(PKT_DEPTH+1)-1:0] o_pkt_count,
    output logic                           o_trunc_pulse
`ifdef ETH_TX_SF_STATS_EN
    ,
    output logic [31:0]                    o_stat_tx_pkts,
    output logic [31:0]                    o_stat_trunc,
    output logic [31:0]                    o_stat_drop_words
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(PKT_DEPTH + 1);
    localparam int WW = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

    state_t        state, state_nxt;
    logic [520:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          sticky, sticky_nxt;
    logic          full, acc, xfer, eop_xfer, load;
    logic          wr_en, wr_sop, wr_eop, wr_err, drop;
    logic [5:0]    wr_empty;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_us_ready = i_tx_rst_n && !full && (o_pkt_count < CW'(PKT_DEPTH));
    assign acc        = i_us_valid && o_us_ready;
    assign xfer       = o_tx_valid && i_tx_ready;
    assign eop_xfer   = xfer && o_tx_endofpacket;
    // The output stage only ever pulls words of complete packets, so valid never gaps mid-packet
    assign load       = (wr_ptr != rd_ptr) && (!o_tx_valid || xfer) && (o_pkt_count > CW'(eop_xfer));

    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        sticky_nxt    = sticky;
        wr_en         = 1'b0;
        wr_sop        = 1'b0;
        wr_eop        = i_us_eop;
        wr_empty      = i_us_empty;
        wr_err        = i_us_error;
        drop          = 1'b0;
        o_trunc_pulse = 1'b0;
        if (acc) begin
            case (state)
                IDLE: begin
                    wr_en      = i_us_sop;
                    wr_sop     = 1'b1;
                    drop       = !i_us_sop;
                    sticky_nxt = 1'b0;
                    wcnt_nxt   = WW'(1);
                    state_nxt  = (i_us_sop && !i_us_eop) ? FRAME : IDLE;
                end
                FRAME: begin
                    wr_en = 1'b1;
                    if (i_us_eop) begin
                        wr_err    = i_us_error | sticky | i_us_sop;
                        state_nxt = IDLE;
                    end else if (wcnt == WW'(MAX_FRAME_WORDS - 1)) begin
                        wr_eop        = 1'b1;
                        wr_empty      = 6'd0;
                        wr_err        = 1'b1;
                        o_trunc_pulse = 1'b1;
                        state_nxt     = DISCARD;
                    end else begin
                        wcnt_nxt   = wcnt + WW'(1);
                        sticky_nxt = sticky | i_us_sop;
                    end
                end
                default: begin
                    drop      = 1'b1;
                    state_nxt = i_us_eop ? IDLE : DISCARD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_tx)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {i_us_data, wr_sop, wr_eop, wr_empty, wr_err};

    always_ff @(posedge i_clk_tx or negedge i_tx_rst_n) begin
        if (!i_tx_rst_n) begin
            state              <= IDLE;
            wcnt               <= '0;
            sticky             <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            o_pkt_count        <= '0;
            o_tx_valid         <= 1'b0;
            o_tx_data          <= '0;
            o_tx_startofpacket <= 1'b0;
            o_tx_endofpacket   <= 1'b0;
            o_tx_empty         <= '0;
            o_tx_error         <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            sticky      <= sticky_nxt;
            wr_ptr      <= wr_ptr + (AW+1)'(wr_en);
            rd_ptr      <= rd_ptr + (AW+1)'(load);
            o_pkt_count <= o_pkt_count + CW'(wr_en && wr_eop) - CW'(eop_xfer);
            o_tx_valid  <= load ? 1'b1 : (xfer ? 1'b0 : o_tx_valid);
            if (load)
                {o_tx_data, o_tx_startofpacket, o_tx_endofpacket, o_tx_empty, o_tx_error} <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef ETH_TX_SF_STATS_EN
    always_ff @(posedge i_clk_tx or negedge i_tx_rst_n) begin
        if (!i_tx_rst_n) begin
            o_stat_tx_pkts    <= '0;
            o_stat_trunc      <= '0;
            o_stat_drop_words <= '0;
        end else begin
            o_stat_tx_pkts    <= o_stat_tx_pkts + 32'(eop_xfer);
            o_stat_trunc      <= o_stat_trunc + 32'(o_trunc_pulse);
            o_stat_drop_words <= o_stat_drop_words + 32'(drop);
        end
    end
`endif
endmodule

// File: tb/tb_eth_100g_tx_sf_buffer.sv
// tb_eth_100g_tx_sf_buffer: scoreboard bench for the store-and-forward TX buffer.
module tb_eth_100g_tx_sf_buffer;
    typedef struct packed {
        logic [511:0] d;
        logic         s;
        logic         e;
        logic [5:0]   m;
        logic         r;
    } w_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         us_valid = 1'b0, us_ready, us_sop = 1'b0, us_eop = 1'b0, us_error = 1'b0;
    logic [511:0] us_data = '0;
    logic [5:0]   us_empty = '0;
    logic         tx_valid, tx_ready = 1'b1, tx_sop, tx_eop, tx_error, trunc;
    logic [511:0] tx_data;
    logic [5:0]   tx_empty;
    logic [4:0]   pkt_count;
`ifdef ETH_TX_SF_STATS_EN
    logic [31:0]  st_pkts, st_trunc, st_drop;
`endif

    int  ncmp = 0, nfail = 0, cyc = 0, acc_cyc = 0;
    int  vdrop = 0, hold_bad = 0, ntrunc = 0;
    bit  tx_mode = 1'b0, tx_hold = 1'b1, in_pkt = 1'b0, held_v = 1'b0;
    w_t  cur, held;
    w_t  exp_q[$], got_q[$];
    int  gcyc[$];

    eth_100g_tx_sf_buffer dut (
        .i_clk_tx(clk), .i_tx_rst_n(rst_n),
        .i_us_valid(us_valid), .o_us_ready(us_ready), .i_us_data(us_data),
        .i_us_sop(us_sop), .i_us_eop(us_eop), .i_us_empty(us_empty), .i_us_error(us_error),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
        .o_tx_startofpacket(tx_sop), .o_tx_endofpacket(tx_eop),
        .o_tx_empty(tx_empty), .o_tx_error(tx_error),
        .o_pkt_count(pkt_count), .o_trunc_pulse(trunc)
`ifdef ETH_TX_SF_STATS_EN
        , .o_stat_tx_pkts(st_pkts), .o_stat_trunc(st_trunc), .o_stat_drop_words(st_drop)
`endif
    );

    always #5 clk = ~clk;
    assign cur = {tx_data, tx_sop, tx_eop, tx_empty, tx_error};

    always @(posedge clk) begin
        #2;
        tx_ready = tx_mode ? ~tx_ready : tx_hold;
    end

    // Output monitor: records every MAC-side transfer and flags valid gaps or unstable stalled data
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (in_pkt && !tx_valid) vdrop <= vdrop + 1;
            if (held_v && cur !== held) hold_bad <= hold_bad + 1;
            held_v <= tx_valid && !tx_ready;
            held   <= cur;
            if (tx_valid && tx_ready) begin
                got_q.push_back(cur);
                gcyc.push_back(cyc);
                in_pkt <= !cur.e;
            end
            if (trunc) ntrunc <= ntrunc + 1;
        end else begin
            in_pkt <= 1'b0;
            held_v <= 1'b0;
        end
    end

    function automatic logic [511:0] rnd();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input w_t w);
        int n = 0;
        bit ok = 1'b0;
        us_valid = 1'b1; us_data = w.d; us_sop = w.s; us_eop = w.e; us_empty = w.m; us_error = w.r;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = us_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        us_valid = 1'b0;
        if (!ok) begin
            ncmp++; nfail++;
            $display("FAIL send_timeout ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic send_frame(input int n, input logic [5:0] m, input logic r);
        w_t w;
        for (int i = 0; i < n; i++) begin
            w.d = rnd(); w.s = (i == 0); w.e = (i == n - 1);
            w.m = w.e ? m : 6'd0; w.r = w.e ? r : 1'b0;
            exp_q.push_back(w);
            send(w);
        end
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        ncmp++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b exp 0", tx_valid); end
        ncmp++; if (us_ready !== 1'b0) begin nfail++; $display("FAIL rst_ready got %b exp 0", us_ready); end
        ncmp++; if (pkt_count !== 5'd0) begin nfail++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
        ncmp++; if (cur !== '0) begin nfail++; $display("FAIL rst_tx_fields got %h exp 0", cur); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ncmp++; if (us_ready !== 1'b1) begin nfail++; $display("FAIL post_rst_ready got %b exp 1", us_ready); end
    endtask

    task automatic test_single();
        w_t e, g;
        int a;
        send_frame(1, 6'd4, 1'b0);
        a = acc_cyc;
        wait_out(1);
        ncmp++;
        if (gcyc.size() < 1 || gcyc[0] != a + 2) begin
            nfail++; $display("FAIL single_latency got %0d exp %0d", gcyc.size() ? gcyc[0] - a : -1, 2);
        end
        ncmp++; if (pkt_count !== 5'd0) begin nfail++; $display("FAIL single_pkt_count got %0d exp 0", pkt_count); end
        ncmp++; if (got_q.size() != exp_q.size()) begin nfail++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() && got_q.size()) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ncmp++; if (g !== e) begin nfail++; $display("FAIL single_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gcyc.delete();
    endtask

    task automatic test_back_to_back();
        w_t e, g;
        for (int f = 0; f < 3; f++) send_frame(5, 6'(f + 1), 1'b0);
        wait_out(15);
        ncmp++;
        if (gcyc.size() != 15 || gcyc[14] - gcyc[0] != 14) begin
            nfail++; $display("FAIL b2b_gap got span %0d over %0d words exp 14 over 15", gcyc.size() ? gcyc[gcyc.size()-1] - gcyc[0] : -1, gcyc.size());
        end
        ncmp++; if (got_q.size() != exp_q.size()) begin nfail++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() && got_q.size()) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ncmp++; if (g !== e) begin nfail++; $display("FAIL b2b_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gcyc.delete();
    endtask

    task automatic test_stall();
        w_t e, g;
        int v0 = vdrop, h0 = hold_bad;
        tx_mode = 1'b1;
        send_frame(10, 6'd9, 1'b1);
        wait_out(10);
        tx_mode = 1'b0; tx_hold = 1'b1;
        ncmp++; if (vdrop != v0) begin nfail++; $display("FAIL stall_valid_gap got %0d exp 0", vdrop - v0); end
        ncmp++; if (hold_bad != h0) begin nfail++; $display("FAIL stall_hold got %0d exp 0", hold_bad - h0); end
        ncmp++; if (got_q.size() != exp_q.size()) begin nfail++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() && got_q.size()) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ncmp++; if (g !== e) begin nfail++; $display("FAIL stall_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gcyc.delete();
    endtask

    task automatic test_truncate();
        w_t w, e, g;
        int t0 = ntrunc;
`ifdef ETH_TX_SF_STATS_EN
        logic [31:0] d0 = st_drop, s0 = st_trunc;
`endif
        for (int i = 0; i < 70; i++) begin
            w.d = rnd(); w.s = (i == 0); w.e = (i == 69); w.m = w.e ? 6'd3 : 6'd0; w.r = 1'b0;
            if (i < 63) exp_q.push_back(w);
            if (i == 63) exp_q.push_back({w.d, 1'b0, 1'b1, 6'd0, 1'b1});
            send(w);
        end
        send_frame(3, 6'd7, 1'b0);
        wait_out(67);
        ncmp++; if (ntrunc - t0 != 1) begin nfail++; $display("FAIL trunc_pulse got %0d exp 1", ntrunc - t0); end
`ifdef ETH_TX_SF_STATS_EN
        ncmp++; if (st_trunc - s0 !== 32'd1) begin nfail++; $display("FAIL stat_trunc got %0d exp 1", st_trunc - s0); end
        ncmp++; if (st_drop - d0 !== 32'd6) begin nfail++; $display("FAIL stat_drop_trunc got %0d exp 6", st_drop - d0); end
`endif
        ncmp++; if (got_q.size() != exp_q.size()) begin nfail++; $display("FAIL trunc_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() && got_q.size()) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ncmp++; if (g !== e) begin nfail++; $display("FAIL trunc_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gcyc.delete();
    endtask

    task automatic test_stray();
        w_t w, e, g;
`ifdef ETH_TX_SF_STATS_EN
        logic [31:0] d0 = st_drop;
`endif
        for (int i = 0; i < 6; i++) begin
            w.d = rnd(); w.s = (i == 2 || i == 4); w.e = (i == 5); w.m = w.e ? 6'd12 : 6'd0; w.r = 1'b0;
            if (i >= 2) exp_q.push_back({w.d, i == 2, w.e, w.m, w.e});
            send(w);
        end
        wait_out(4);
`ifdef ETH_TX_SF_STATS_EN
        ncmp++; if (st_drop - d0 !== 32'd2) begin nfail++; $display("FAIL stat_drop_stray got %0d exp 2", st_drop - d0); end
`endif
        ncmp++; if (got_q.size() != exp_q.size()) begin nfail++; $display("FAIL stray_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() && got_q.size()) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            ncmp++; if (g !== e) begin nfail++; $display("FAIL stray_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); gcyc.delete();
    endtask

    task automatic test_full_reset();
        tx_hold = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_frame(1, 6'(i), 1'b0);
        @(negedge clk);
        ncmp++; if (us_ready !== 1'b0) begin nfail++; $display("FAIL full_ready got %b exp 0", us_ready); end
        ncmp++; if (pkt_count !== 5'd16) begin nfail++; $display("FAIL full_pkt_count got %0d exp 16", pkt_count); end
        ncmp++; if (tx_valid !== 1'b1) begin nfail++; $display("FAIL full_valid got %b exp 1", tx_valid); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        ncmp++; if (tx_valid !== 1'b0) begin nfail++; $display("FAIL async_rst_valid got %b exp 0", tx_valid); end
        ncmp++; if (pkt_count !== 5'd0) begin nfail++; $display("FAIL async_rst_pkt_count got %0d exp 0", pkt_count); end
        ncmp++; if (us_ready !== 1'b0) begin nfail++; $display("FAIL async_rst_ready got %b exp 0", us_ready); end
        ncmp++; if (cur !== '0) begin nfail++; $display("FAIL async_rst_fields got %h exp 0", cur); end
        exp_q.delete(); got_q.delete(); gcyc.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1; tx_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_truncate();
        test_stray();
        test_full_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
